addsub_sat_pipe: RTL and testbench
==================================

Name: addsub_sat_pipe

Overview:
- Parametrised successor to the single-cycle subtractor: a pipelined add/subtract unit with runtime-selectable operation, signed/unsigned mode and optional saturation.
- Uses a valid/ready handshake with backpressure and reports per-result status flags plus a sticky overflow event counter.
- Sits between the datapath's operand producers and accumulate/compare stages.

Parameters:
- BIT, 32, operand and result width (>= 4).
- PIPE_STAGES, 2, number of register stages from input to output (1..4); unstalled latency in cycles.
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- data_in_valid  input  1  operand beat valid.
- data_in_ready  output  1  block can accept a beat this cycle.
- A_in  input  BIT  operand A.
- B_in  input  BIT  operand B.
- op  input  2  operation: 00 A+B, 01 A-B, 10 B-A, 11 |A-B|; sampled with the beat.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the beat.
- sat_en  input  1  1 = clamp to range, 0 = wrap (low BIT bits); sampled with the beat.
- data_out_valid  output  1  result beat valid.
- data_out_ready  input  1  downstream accepts the result.
- C_out  output  BIT  result.
- ovf_out  output  1  true result was out of range for the selected mode.
- neg_out  output  1  true (pre-clamp) result < 0.
- zero_out  output  1  C_out == 0.
- ovf_cnt  output  CNT_W  count of accepted output beats with ovf_out=1.
- ovf_cnt_clr  input  1  clear ovf_cnt.

Behaviour:
- Reset (rst_n=0 at a clk edge): all stage valids, data_out_valid, C_out, ovf_out, neg_out, zero_out and ovf_cnt go to 0. Mid-stream beats are discarded. data_in_ready is 1 in the first cycle after reset deasserts.
- Input transfer: data_in_valid && data_in_ready. Output transfer: data_out_valid && data_out_ready.
- Pipeline:
  - PIPE_STAGES register stages, each with its own valid bit.
  - A stage loads when it is empty or its successor loads/drains in the same cycle (bubble-collapsing).
  - data_in_ready = stage 1 can load, computed combinationally from the valids and data_out_ready; no combinational path from data_in_valid.
  - Unstalled latency = PIPE_STAGES cycles. Throughput is 1 beat/cycle while data_out_ready=1.
  - Output holds C_out and the flags stable while data_out_valid && !data_out_ready.
  - Beats are never dropped, duplicated or reordered.
- Arithmetic, computed in stage 1 at width BIT+2:
  - Operands are sign-extended (is_signed=1) or zero-extended (is_signed=0).
  - The true result R is the exact value of the selected op.
  - Range: signed [-2^(BIT-1), 2^(BIT-1)-1]; unsigned [0, 2^BIT-1].
  - ovf = R outside range. neg = R < 0.
  - sat_en=1: C_out = R clamped to the nearest range bound.
  - sat_en=0: C_out = R[BIT-1:0].
  - zero is evaluated on the final C_out.
  - |A-B| with is_signed=1 can reach 2^BIT-1 and sets ovf when above the signed max. Unsigned |A-B| never overflows.
  - Later stages only delay the result and flags.
- Counter:
  - ovf_cnt increments by 1 on each output transfer with ovf_out=1 and saturates at 2^CNT_W-1 (no wrap).
  - ovf_cnt_clr=1 sets it to 0 next cycle, overriding a same-cycle increment.
- Mode inputs are per-beat; changing them between beats needs no flush.

Test Plan:
- BIT=8, unsigned, op=01, A=5, B=7, sat_en=0 -> C_out=0xFE, ovf=1, neg=1, zero=0 after exactly PIPE_STAGES cycles. Same beat with sat_en=1 -> C_out=0x00, ovf=1, zero=1.
- BIT=8, signed, op=00, A=100, B=50: sat_en=0 -> C_out=0x96, ovf=1. sat_en=1 -> C_out=0x7F, ovf=1, neg=0.
- BIT=8, signed, op=11, A=0x80, B=0x7F, sat_en=1 -> C_out=0x7F, ovf=1. Unsigned, same operands -> C_out=0x01, ovf=0. op=10, A=3, B=3 -> C_out=0, zero=1.
- Stream 8 beats with data_out_ready held 0 -> data_in_ready drops after PIPE_STAGES beats are accepted. Release ready -> all 8 results emerge in order, one per cycle, unchanged while stalled.
- Assert rst_n=0 for one cycle with 2 beats in flight -> next cycle data_out_valid=0, ovf_cnt=0, C_out=0, data_in_ready=1. No stale beats appear afterwards.
- CNT_W=2: 5 overflowing beats -> ovf_cnt=3 (saturated). ovf_cnt_clr on the same cycle as an overflow output transfer -> ovf_cnt=0.

Source files
------------

// File: rtl/addsub_sat_pipe.sv
// Pipelined add/sub/abs-diff with signed/unsigned mode, optional saturation and status flags.
// Latency PIPE_STAGES cycles; valid/ready with bubble-collapsing stalls, output held while not ready.
module addsub_sat_pipe #(
  parameter int BIT         = 32,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  input  logic [BIT-1:0]   A_in,
  input  logic [BIT-1:0]   B_in,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic             sat_en,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic [BIT-1:0]   C_out,
  output logic             ovf_out,
  output logic             neg_out,
  output logic             zero_out,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             ovf_cnt_clr
);

  localparam int W = BIT + 2;
  localparam logic signed [W-1:0] SMAX = {3'b000, {(BIT-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {3'b111, {(BIT-1){1'b0}}};
  localparam logic signed [W-1:0] UMAX = {2'b00, {BIT{1'b1}}};

  typedef struct packed {
    logic [BIT-1:0] c;
    logic           ovf;
    logic           neg;
    logic           zero;
  } res_t;

  logic signed [W-1:0] a_x, b_x, r;
  logic                hi, lo;
  res_t                s1;

  // Two guard bits hold every exact result: unsigned sums up to 2^(BIT+1)-2,
  // signed |A-B| up to 2^BIT-1.
  always_comb begin
    a_x = is_signed ? {{2{A_in[BIT-1]}}, A_in} : {2'b00, A_in};
    b_x = is_signed ? {{2{B_in[BIT-1]}}, B_in} : {2'b00, B_in};
    case (op)
      2'b00:   r = a_x + b_x;
      2'b01:   r = a_x - b_x;
      2'b10:   r = b_x - a_x;
      default: r = (a_x >= b_x) ? (a_x - b_x) : (b_x - a_x);
    endcase
    hi = is_signed ? (r > SMAX) : (r > UMAX);
    lo = is_signed ? (r < SMIN) : r[W-1];
    s1.ovf = hi | lo;
    s1.neg = r[W-1];
    s1.c   = r[BIT-1:0];
    if (sat_en && hi) begin
      s1.c = is_signed ? SMAX[BIT-1:0] : UMAX[BIT-1:0];
    end else if (sat_en && lo) begin
      s1.c = is_signed ? SMIN[BIT-1:0] : '0;
    end
    s1.zero = (s1.c == '0);
  end

  logic [PIPE_STAGES-1:0] vld, load, src_vld;
  res_t                   dat     [PIPE_STAGES];
  res_t                   src_dat [PIPE_STAGES];

  // A stage may load unless it and every stage after it are full while the output is stalled.
  always_comb begin
    for (int i = 0; i < PIPE_STAGES; i++) begin
      logic full;
      full = 1'b1;
      for (int j = i; j < PIPE_STAGES; j++) begin
        full = full & vld[j];
      end
      load[i] = data_out_ready | ~full;
    end
  end

  always_comb begin
    src_vld[0] = data_in_valid;
    src_dat[0] = s1;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      src_vld[i] = vld[i-1];
      src_dat[i] = dat[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        dat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        if (load[i]) begin
          vld[i] <= src_vld[i];
          dat[i] <= src_dat[i];
        end
      end
    end
  end

  assign data_in_ready  = load[0];
  assign data_out_valid = vld[PIPE_STAGES-1];
  assign C_out          = dat[PIPE_STAGES-1].c;
  assign ovf_out        = dat[PIPE_STAGES-1].ovf;
  assign neg_out        = dat[PIPE_STAGES-1].neg;
  assign zero_out       = dat[PIPE_STAGES-1].zero;

  always_ff @(posedge clk) begin
    if (!rst_n || ovf_cnt_clr) begin
      ovf_cnt <= '0;
    end else if (data_out_valid && data_out_ready && ovf_out && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_addsub_sat_pipe.sv
// Directed bench for addsub_sat_pipe at BIT=8, PIPE_STAGES=2, CNT_W=2.
module tb_addsub_sat_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_in_valid;
  logic       data_in_ready;
  logic [7:0] A_in, B_in;
  logic [1:0] op;
  logic       is_signed, sat_en;
  logic       data_out_valid, data_out_ready;
  logic [7:0] C_out;
  logic       ovf_out, neg_out, zero_out;
  logic [1:0] ovf_cnt;
  logic       ovf_cnt_clr;

  int nchk = 0;
  int nfail = 0;

  addsub_sat_pipe #(.BIT(8), .PIPE_STAGES(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .A_in(A_in), .B_in(B_in), .op(op), .is_signed(is_signed), .sat_en(sat_en),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .C_out(C_out), .ovf_out(ovf_out), .neg_out(neg_out), .zero_out(zero_out),
    .ovf_cnt(ovf_cnt), .ovf_cnt_clr(ovf_cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a, b;
    logic [1:0] op;
    logic       s, sat;
    logic [7:0] c;
    logic       ovf, neg, zero;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ovf_beat();
    data_in_valid = 1'b1; A_in = 8'hFF; B_in = 8'h01; op = 2'b00; is_signed = 1'b0; sat_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b1; ovf_cnt_clr = 1'b0;
    A_in = '0; B_in = '0; op = '0; is_signed = 1'b0; sat_en = 1'b0;
    step(); step();
    nchk++; if (data_out_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b expected 0", data_out_valid); end
    nchk++; if (C_out !== 8'h00) begin nfail++; $display("FAIL reset_c: got %h expected 00", C_out); end
    nchk++; if ({ovf_out, neg_out, zero_out} !== 3'b000) begin nfail++; $display("FAIL reset_flags: got %b expected 000", {ovf_out, neg_out, zero_out}); end
    nchk++; if (ovf_cnt !== 2'd0) begin nfail++; $display("FAIL reset_cnt: got %0d expected 0", ovf_cnt); end
    rst_n = 1'b1;
    #1;
    nchk++; if (data_in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready: got %b expected 1", data_in_ready); end
  endtask

  task automatic test_arith();
    vec_t tv[14];
    tv[0]  = '{8'h05, 8'h07, 2'b01, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b1, 1'b0};
    tv[1]  = '{8'h05, 8'h07, 2'b01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
    tv[2]  = '{8'h64, 8'h32, 2'b00, 1'b1, 1'b0, 8'h96, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{8'h64, 8'h32, 2'b00, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{8'h80, 8'h7F, 2'b11, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{8'h80, 8'h7F, 2'b11, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{8'h03, 8'h03, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tv[7]  = '{8'h80, 8'h01, 2'b01, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
    tv[8]  = '{8'h80, 8'h01, 2'b01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
    tv[9]  = '{8'hC8, 8'h64, 2'b00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tv[10] = '{8'hC8, 8'h64, 2'b00, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0, 1'b0};
    tv[11] = '{8'h05, 8'hFB, 2'b10, 1'b1, 1'b1, 8'hF6, 1'b0, 1'b1, 1'b0};
    tv[12] = '{8'hFB, 8'h05, 2'b11, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0};
    tv[13] = '{8'h80, 8'h7F, 2'b11, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    data_out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      data_in_valid = 1'b1; A_in = tv[i].a; B_in = tv[i].b; op = tv[i].op;
      is_signed = tv[i].s; sat_en = tv[i].sat;
      step();
      data_in_valid = 1'b0;
      nchk++; if (data_out_valid !== 1'b0) begin nfail++; $display("FAIL arith_early[%0d]: got valid %b expected 0", i, data_out_valid); end
      step();
      nchk++; if (data_out_valid !== 1'b1) begin nfail++; $display("FAIL arith_latency[%0d]: got valid %b expected 1", i, data_out_valid); end
      nchk++; if (C_out !== tv[i].c) begin nfail++; $display("FAIL arith_c[%0d]: got %h expected %h", i, C_out, tv[i].c); end
      nchk++; if ({ovf_out, neg_out, zero_out} !== {tv[i].ovf, tv[i].neg, tv[i].zero})
        begin nfail++; $display("FAIL arith_flags[%0d]: got ovf/neg/zero %b expected %b", i, {ovf_out, neg_out, zero_out}, {tv[i].ovf, tv[i].neg, tv[i].zero}); end
    end
    step();
  endtask

  task automatic test_counter();
    data_out_ready = 1'b1; data_in_valid = 1'b0;
    ovf_cnt_clr = 1'b1; step(); ovf_cnt_clr = 1'b0;
    nchk++; if (ovf_cnt !== 2'd0) begin nfail++; $display("FAIL cnt_clear: got %0d expected 0", ovf_cnt); end
    for (int i = 0; i < 5; i++) begin
      ovf_beat();
      step();
    end
    data_in_valid = 1'b0;
    step(); step(); step();
    nchk++; if (ovf_cnt !== 2'd3) begin nfail++; $display("FAIL cnt_saturate: got %0d expected 3", ovf_cnt); end
    ovf_beat(); step(); data_in_valid = 1'b0; step();
    nchk++; if (data_out_valid !== 1'b1 || ovf_out !== 1'b1) begin nfail++; $display("FAIL cnt_collide_setup: got valid/ovf %b%b expected 11", data_out_valid, ovf_out); end
    ovf_cnt_clr = 1'b1; step(); ovf_cnt_clr = 1'b0;
    nchk++; if (ovf_cnt !== 2'd0) begin nfail++; $display("FAIL cnt_clr_priority: got %0d expected 0", ovf_cnt); end
    ovf_beat(); step(); data_in_valid = 1'b0; step(); step();
    nchk++; if (ovf_cnt !== 2'd1) begin nfail++; $display("FAIL cnt_increment: got %0d expected 1", ovf_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expq[8];
    int sent, got, gaps;
    logic started, acc, xfer;
    for (int i = 0; i < 8; i++) expq[i] = 8'(11 * (i + 1));
    sent = 0; got = 0; gaps = 0; started = 1'b0;
    data_out_ready = 1'b0;
    data_in_valid = 1'b1; A_in = 8'd10; B_in = 8'd1; op = 2'b00; is_signed = 1'b0; sat_en = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      if (cyc == 6) begin
        nchk++; if (sent != 2) begin nfail++; $display("FAIL stall_accepted: got %0d expected 2", sent); end
        nchk++; if (data_in_ready !== 1'b0) begin nfail++; $display("FAIL stall_in_ready: got %b expected 0", data_in_ready); end
        nchk++; if (data_out_valid !== 1'b1 || C_out !== 8'd11) begin nfail++; $display("FAIL stall_hold: got valid %b C %h expected 1 0b", data_out_valid, C_out); end
        data_out_ready = 1'b1;
        #1;
      end
      acc  = data_in_valid & data_in_ready;
      xfer = data_out_valid & data_out_ready;
      if (xfer) begin
        nchk++; if (C_out !== expq[got]) begin nfail++; $display("FAIL stream_order[%0d]: got %h expected %h", got, C_out, expq[got]); end
        got++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      step();
      if (acc) begin
        sent++;
        if (sent < 8) begin A_in = 8'(10 * (sent + 1)); B_in = 8'(sent + 1); end
        else data_in_valid = 1'b0;
      end
    end
    data_in_valid = 1'b0;
    nchk++; if (got != 8) begin nfail++; $display("FAIL stream_count: got %0d results expected 8", got); end
    nchk++; if (gaps != 0) begin nfail++; $display("FAIL stream_gaps: got %0d bubbles expected 0", gaps); end
    step();
    nchk++; if (data_out_valid !== 1'b0) begin nfail++; $display("FAIL stream_extra: got valid %b expected 0", data_out_valid); end
  endtask

  task automatic test_midstream_reset();
    int stale;
    data_out_ready = 1'b1;
    ovf_beat(); step();
    A_in = 8'hF0; B_in = 8'h20; step();
    data_in_valid = 1'b0;
    nchk++; if (data_out_valid !== 1'b1) begin nfail++; $display("FAIL inflight_setup: got valid %b expected 1", data_out_valid); end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    #1;
    nchk++; if (data_out_valid !== 1'b0) begin nfail++; $display("FAIL midrst_valid: got %b expected 0", data_out_valid); end
    nchk++; if (ovf_cnt !== 2'd0) begin nfail++; $display("FAIL midrst_cnt: got %0d expected 0", ovf_cnt); end
    nchk++; if (C_out !== 8'h00) begin nfail++; $display("FAIL midrst_c: got %h expected 00", C_out); end
    nchk++; if (data_in_ready !== 1'b1) begin nfail++; $display("FAIL midrst_in_ready: got %b expected 1", data_in_ready); end
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (data_out_valid) stale++;
    end
    nchk++; if (stale != 0) begin nfail++; $display("FAIL midrst_stale: got %0d stale beats expected 0", stale); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_counter();
    test_back_to_back();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
